// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with saturating counters, zero-latency
// lookup from PCF, training and misprediction detection from Execute.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int MODE     = 1,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   PCF,
  output logic              PredTakenF,
  output logic [XLEN-1:0]   PredTargetF,
  input  logic              upd_en,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_is_jump,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  output logic              MispredictE,
  output logic [STAT_W-1:0] upd_count,
  output logic [STAT_W-1:0] mispred_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT   = CTR_BITS'(2 ** (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);
  localparam logic [STAT_W-1:0]   STAT_MAX = '1;

  logic                r_valid  [ENTRIES];
  logic [TAG_W-1:0]    r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
  logic [STAT_W-1:0]   r_upd_count;
  logic [STAT_W-1:0]   r_mispred_count;

  logic [IDX-1:0]      w_lk_idx;
  logic [IDX-1:0]      w_up_idx;
  logic [TAG_W-1:0]    w_lk_tag;
  logic [TAG_W-1:0]    w_up_tag;
  logic                w_lk_hit;
  logic                w_up_hit;
  logic [CTR_BITS-1:0] w_ctr_cur;
  logic [CTR_BITS-1:0] w_ctr_next;
  logic                w_unused;

  assign w_lk_idx = PCF[IDX+1:2];
  assign w_lk_tag = PCF[XLEN-1:IDX+2];
  assign w_up_idx = upd_pc[IDX+1:2];
  assign w_up_tag = upd_pc[XLEN-1:IDX+2];
  assign w_unused = ^{PCF[1:0], upd_pc[1:0]};

  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  assign PredTakenF  = (MODE == 1) && w_lk_hit && r_ctr[w_lk_idx][CTR_BITS-1];
  assign PredTargetF = PredTakenF ? r_target[w_lk_idx] : '0;

  assign MispredictE = upd_en && ((upd_taken != upd_pred_taken) ||
                                  (upd_taken && (upd_pred_target != upd_target)));

  assign w_ctr_cur = r_ctr[w_up_idx];

  // Saturating counter step; jumps pin the counter to strongly taken.
  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (upd_is_jump) begin
      w_ctr_next = CTR_MAX;
    end else if (upd_taken) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_next = w_ctr_cur + 1'b1;
    end else begin
      if (w_ctr_cur != '0) w_ctr_next = w_ctr_cur - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_WNT;
      end
    end else if (upd_en && (MODE == 1)) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_next;
        if (upd_taken) r_target[w_up_idx] <= upd_target;
      end else if (upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= upd_target;
        r_ctr[w_up_idx]    <= upd_is_jump ? CTR_MAX : CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_count     <= '0;
      r_mispred_count <= '0;
    end else begin
      if (upd_en && (r_upd_count != STAT_MAX))
        r_upd_count <= r_upd_count + 1'b1;
      if (MispredictE && (r_mispred_count != STAT_MAX))
        r_mispred_count <= r_mispred_count + 1'b1;
    end
  end

  assign upd_count     = r_upd_count;
  assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a dynamic (MODE=1) and a static (MODE=0) instance share
// stimulus; outputs are compared to a table model built from the prediction rules.
module tb_branch_predictor;
  localparam int XLEN = 32, ENTRIES = 16, CTR_BITS = 2, STAT_W = 16;
  localparam int CMAX = 2 ** CTR_BITS - 1;
  localparam int CWT  = 2 ** (CTR_BITS - 1);
  localparam int unsigned SMAX = 2 ** STAT_W - 1;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] PCF;
  logic upd_en, upd_taken, upd_is_jump, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic p1_taken, p0_taken, m1, m0;
  logic [31:0] p1_target, p0_target;
  logic [15:0] u1, mc1, u0, mc0;

  int total = 0;
  int bad   = 0;

  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int unsigned m_upd = 0, m_mis = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .MODE(1), .STAT_W(STAT_W)) u_dyn (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(p1_taken), .PredTargetF(p1_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_is_jump(upd_is_jump), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .MispredictE(m1), .upd_count(u1), .mispred_count(mc1));

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .MODE(0), .STAT_W(STAT_W)) u_static (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(p0_taken), .PredTargetF(p0_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_is_jump(upd_is_jump), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .MispredictE(m0), .upd_count(u0), .mispred_count(mc0));

  function automatic int unsigned slot(logic [31:0] pc);
    int unsigned p = pc;
    return (p / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tagof(logic [31:0] pc);
    int unsigned p = pc;
    return p / (4 * ENTRIES);
  endfunction

  function automatic bit mdl_hit(logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
  endfunction

  function automatic bit mdl_taken(logic [31:0] pc);
    return mdl_hit(pc) && (m_ctr[slot(pc)] >= CWT);
  endfunction

  function automatic logic [31:0] mdl_tgt(logic [31:0] pc);
    return mdl_taken(pc) ? m_target[slot(pc)] : 32'h0;
  endfunction

  function automatic bit mdl_mis();
    return upd_en && ((upd_taken != upd_pred_taken) || (upd_taken && (upd_pred_target != upd_target)));
  endfunction

  function automatic void mdl_clock();
    int unsigned s;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = CWT - 1;
      end
      m_upd = 0;
      m_mis = 0;
    end else if (upd_en) begin
      if (mdl_mis() && m_mis < SMAX) m_mis++;
      if (m_upd < SMAX) m_upd++;
      s = slot(upd_pc);
      if (mdl_hit(upd_pc)) begin
        if (upd_is_jump)    m_ctr[s] = CMAX;
        else if (upd_taken) m_ctr[s] = (m_ctr[s] + 1 > CMAX) ? CMAX : m_ctr[s] + 1;
        else                m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        if (upd_taken) m_target[s] = upd_target;
      end else if (upd_taken) begin
        m_valid[s]  = 1'b1;
        m_tag[s]    = tagof(upd_pc);
        m_target[s] = upd_target;
        m_ctr[s]    = upd_is_jump ? CMAX : CWT;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    mdl_clock();
    #1;
  endtask

  task automatic drive(input bit en, input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                       input bit jmp, input bit ptk, input logic [31:0] ptgt);
    upd_en = en; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_is_jump = jmp; upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 32'h100, 1, 32'h80, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    PCF = 32'h100; #1;
    total++; if (p1_taken !== 1'b0) begin bad++; $display("FAIL reset_pred got=%0b exp=0", p1_taken); end
    total++; if (p1_target !== 32'h0) begin bad++; $display("FAIL reset_target got=%h exp=0", p1_target); end
    total++; if (u1 !== 16'd0 || u0 !== 16'd0) begin bad++; $display("FAIL reset_upd got=%0d/%0d exp=0", u1, u0); end
    total++; if (mc1 !== 16'd0 || mc0 !== 16'd0) begin bad++; $display("FAIL reset_mis got=%0d/%0d exp=0", mc1, mc0); end
  endtask

  task automatic test_allocate();
    drive(1, 32'h100, 1, 32'h80, 0, 0, 0);
    PCF = 32'h100; #1;
    total++; if (m1 !== 1'b1 || m0 !== 1'b1) begin bad++; $display("FAIL alloc_mispredE got=%0b/%0b exp=1", m1, m0); end
    total++; if (p1_taken !== 1'b0) begin bad++; $display("FAIL alloc_pre_pred got=%0b exp=0", p1_taken); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (p1_taken !== 1'b1 || p1_target !== 32'h80) begin bad++; $display("FAIL alloc_pred got=%0b/%h exp=1/80", p1_taken, p1_target); end
    total++; if (u1 !== 16'd1 || mc1 !== 16'd1) begin bad++; $display("FAIL alloc_stats got=%0d/%0d exp=1/1", u1, mc1); end
  endtask

  task automatic test_train_down();
    drive(1, 32'h100, 0, 0, 0, 1, 32'h80); #1;
    total++; if (m1 !== 1'b1) begin bad++; $display("FAIL train1_mispredE got=%0b exp=1", m1); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (p1_taken !== 1'b0 || p1_target !== 32'h0) begin bad++; $display("FAIL train1_pred got=%0b/%h exp=0/0", p1_taken, p1_target); end
    drive(1, 32'h100, 0, 0, 0, 0, 0); #1;
    total++; if (m1 !== 1'b0) begin bad++; $display("FAIL train2_mispredE got=%0b exp=0", m1); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (p1_taken !== 1'b0) begin bad++; $display("FAIL train2_pred got=%0b exp=0", p1_taken); end
    total++; if (u1 !== 16'd3 || mc1 !== 16'd2) begin bad++; $display("FAIL train_stats got=%0d/%0d exp=3/2", u1, mc1); end
  endtask

  task automatic test_alias();
    // counter at 0: two taken updates bring 0x100 back to weakly taken
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h100, 1, 32'h80, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    PCF = 32'h100; #1;
    total++; if (p1_taken !== 1'b1 || p1_target !== 32'h80) begin bad++; $display("FAIL alias_base got=%0b/%h exp=1/80", p1_taken, p1_target); end
    PCF = 32'h140; #1;
    total++; if (p1_taken !== 1'b0 || p1_target !== 32'h0) begin bad++; $display("FAIL alias_miss got=%0b/%h exp=0/0", p1_taken, p1_target); end
    drive(1, 32'h140, 1, 32'h300, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (p1_taken !== 1'b1 || p1_target !== 32'h300) begin bad++; $display("FAIL alias_new got=%0b/%h exp=1/300", p1_taken, p1_target); end
    PCF = 32'h100; #1;
    total++; if (p1_taken !== 1'b0) begin bad++; $display("FAIL alias_evicted got=%0b exp=0", p1_taken); end
  endtask

  task automatic test_jump_saturation();
    drive(1, 32'h200, 1, 32'h400, 1, 0, 0);
    PCF = 32'h200;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (p1_taken !== 1'b1 || p1_target !== 32'h400) begin bad++; $display("FAIL jump_alloc got=%0b/%h exp=1/400", p1_taken, p1_target); end
    drive(1, 32'h200, 0, 0, 0, 1, 32'h400);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (p1_taken !== 1'b1) begin bad++; $display("FAIL jump_nt_once got=%0b exp=1", p1_taken); end
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h200, 1, 32'h400, 0, 1, 32'h400); #1;
      if (i == 0) begin
        total++; if (m1 !== 1'b0) begin bad++; $display("FAIL jump_correct_mispredE got=%0b exp=0", m1); end
      end
      tick();
    end
    drive(1, 32'h200, 0, 0, 0, 1, 32'h400);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (p1_taken !== 1'b1) begin bad++; $display("FAIL sat_high_nt1 got=%0b exp=1", p1_taken); end
    drive(1, 32'h200, 0, 0, 0, 1, 32'h400);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (p1_taken !== 1'b0) begin bad++; $display("FAIL sat_high_nt2 got=%0b exp=0", p1_taken); end
  endtask

  task automatic test_same_cycle();
    PCF = 32'h100;
    drive(1, 32'h100, 1, 32'h500, 0, 0, 0); #1;
    total++; if (p1_taken !== 1'b0) begin bad++; $display("FAIL same_alloc_old got=%0b exp=0", p1_taken); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (p1_taken !== 1'b1 || p1_target !== 32'h500) begin bad++; $display("FAIL same_alloc_new got=%0b/%h exp=1/500", p1_taken, p1_target); end
    drive(1, 32'h100, 0, 0, 0, 1, 32'h500); #1;
    total++; if (p1_taken !== 1'b1 || p1_target !== 32'h500) begin bad++; $display("FAIL same_train_old got=%0b/%h exp=1/500", p1_taken, p1_target); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (p1_taken !== 1'b0) begin bad++; $display("FAIL same_train_new got=%0b exp=0", p1_taken); end
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h100, 1, 32'h600, 1, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    PCF = 32'h100; #1;
    total++; if (p1_taken !== 1'b0 || p1_target !== 32'h0) begin bad++; $display("FAIL rstmid_pred100 got=%0b/%h exp=0/0", p1_taken, p1_target); end
    PCF = 32'h200; #1;
    total++; if (p1_taken !== 1'b0) begin bad++; $display("FAIL rstmid_pred200 got=%0b exp=0", p1_taken); end
    total++; if (u1 !== 16'd0 || mc1 !== 16'd0 || u0 !== 16'd0 || mc0 !== 16'd0)
      begin bad++; $display("FAIL rstmid_stats got=%0d/%0d/%0d/%0d exp=0", u1, mc1, u0, mc0); end
  endtask

  task automatic test_mode0();
    PCF = 32'h300;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h300, 1, 32'h700, (i == 0), 0, 0); #1;
      total++; if (p0_taken !== 1'b0 || p0_target !== 32'h0) begin bad++; $display("FAIL mode0_pred got=%0b/%h exp=0/0", p0_taken, p0_target); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    total++; if (p0_taken !== 1'b0) begin bad++; $display("FAIL mode0_after got=%0b exp=0", p0_taken); end
    total++; if (u0 !== 16'd4 || mc0 !== 16'd4) begin bad++; $display("FAIL mode0_stats got=%0d/%0d exp=4/4", u0, mc0); end
    total++; if (p1_taken !== 1'b1 || p1_target !== 32'h700) begin bad++; $display("FAIL mode1_learned got=%0b/%h exp=1/700", p1_taken, p1_target); end
  endtask

  function automatic logic [31:0] rand_pc();
    int unsigned t = $urandom_range(0, 3);
    int unsigned i = $urandom_range(0, ENTRIES - 1);
    int unsigned l = $urandom_range(0, 3);
    return 32'((t * 4 * ENTRIES) + (i * 4) + l);
  endfunction

  function automatic logic [31:0] rand_tgt();
    return 32'h1000 + 32'($urandom_range(0, 7) * 4);
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] upc, tgt, ptgt;
      bit jmp, tk, ptk;
      upc  = rand_pc();
      jmp  = ($urandom_range(0, 5) == 0);
      tk   = jmp || ($urandom_range(0, 1) == 1);
      tgt  = rand_tgt();
      ptk  = mdl_taken(upc);
      if ($urandom_range(0, 7) == 0) ptk = !ptk;
      ptgt = ptk ? mdl_tgt(upc) : 32'h0;
      if ($urandom_range(0, 7) == 0) ptgt = rand_tgt();
      drive($urandom_range(0, 3) != 0, upc, tk, tgt, jmp, ptk, ptgt);
      PCF = ($urandom_range(0, 3) == 0) ? upc : rand_pc();
      #1;
      total++; if (p1_taken !== mdl_taken(PCF) || p1_target !== mdl_tgt(PCF))
        begin bad++; $display("FAIL rnd_pred pc=%h got=%0b/%h exp=%0b/%h", PCF, p1_taken, p1_target, mdl_taken(PCF), mdl_tgt(PCF)); end
      total++; if (m1 !== mdl_mis() || m0 !== mdl_mis())
        begin bad++; $display("FAIL rnd_mispredE got=%0b/%0b exp=%0b", m1, m0, mdl_mis()); end
      total++; if (p0_taken !== 1'b0 || p0_target !== 32'h0)
        begin bad++; $display("FAIL rnd_mode0_pred got=%0b/%h exp=0/0", p0_taken, p0_target); end
      total++; if (u1 !== 16'(m_upd) || mc1 !== 16'(m_mis) || u0 !== 16'(m_upd) || mc0 !== 16'(m_mis))
        begin bad++; $display("FAIL rnd_stats got=%0d/%0d/%0d/%0d exp=%0d/%0d", u1, mc1, u0, mc0, m_upd, m_mis); end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    PCF = 32'h0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    test_reset();
    test_allocate();
    test_train_down();
    test_alias();
    test_jump_saturation();
    test_same_cycle();
    test_reset_mid();
    test_mode0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RV32I pipeline.
- Predicts taken/target in Fetch from PCF using a direct-mapped BTB with saturating counters.
- Trains from Execute with the resolved outcome and flags mispredictions for FlushD/FlushE.
- Replaces the fixed resolve-in-E, predict-not-taken scheme; MODE=0 reproduces that scheme exactly.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, BTB entries; power of 2, >=2; IDX=log2(ENTRIES)
CTR_BITS, 2, saturating counter width, >=1
MODE, 1, 0 = static not-taken (table never written), 1 = dynamic bimodal
STAT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
PCF  in  XLEN  fetch PC for lookup
PredTakenF  out  1  prediction: taken
PredTargetF  out  XLEN  predicted target; 0 when PredTakenF=0
upd_en  in  1  resolved branch/jump in Execute this cycle
upd_pc  in  XLEN  PC of resolved instruction (PCE)
upd_taken  in  1  actual outcome (PCSrcE)
upd_target  in  XLEN  actual target
upd_is_jump  in  1  unconditional jump (JAL/JALR)
upd_pred_taken  in  1  prediction carried down pipeline for this instr
upd_pred_target  in  XLEN  predicted target carried down pipeline
MispredictE  out  1  combinational misprediction flag
upd_count  out  STAT_W  number of updates
mispred_count  out  STAT_W  number of mispredictions

Behaviour:
- Reset: synchronous, active-high; one clk edge with rst=1 required.
- Reset state: all valid=0; all counters = 2^(CTR_BITS-1)-1 (weakly not-taken); upd_count=0; mispred_count=0.
- Reset outputs: PredTakenF=0, PredTargetF=0.
- rst overrides a simultaneous upd_en; the update is dropped.
- Entry fields: valid, tag, target[XLEN-1:0], ctr[CTR_BITS-1:0].
- Index = pc[IDX+1:2]. Tag = pc[XLEN-1:IDX+2]. pc[1:0] is ignored.
- Lookup: combinational, zero latency from PCF.
- hit = valid && tag==PCF tag.
- PredTakenF = (MODE==1) && hit && ctr[MSB].
- PredTargetF = target if PredTakenF, else 0.
- MispredictE = upd_en && ((upd_taken != upd_pred_taken) || (upd_taken && upd_pred_target != upd_target)). Purely combinational.
- Update: applied at the rising clk edge when upd_en && MODE==1.
  - Hit, upd_is_jump: ctr = max.
  - Hit, upd_taken: ctr = min(ctr+1, max).
  - Hit, not taken: ctr = max(ctr-1, 0).
  - Hit, taken: target = upd_target. Not taken: target unchanged.
  - Miss, upd_taken: allocate/overwrite: valid=1, tag=upd_pc tag, target=upd_target, ctr = max if upd_is_jump, else 2^(CTR_BITS-1) (weakly taken).
  - Miss, not taken: no change.
- max = 2^CTR_BITS-1. Counters saturate at both ends and never wrap.
- Same cycle lookup and update to the same index: lookup returns pre-edge contents; the new contents are visible from the next cycle.
- Statistics:
  - upd_count += 1 on every upd_en (both MODEs).
  - mispred_count += 1 when MispredictE=1.
  - Both saturate at 2^STAT_W-1; no wrap.
- MODE=0: table is never written; PredTakenF is always 0; statistics still count.

Test Plan:
- Reset (ENTRIES=16, CTR_BITS=2): after rst, PCF=0x100 -> PredTakenF=0, PredTargetF=0, upd_count=0, mispred_count=0.
- Allocate: upd_en, upd_pc=0x100, upd_taken=1, upd_target=0x80, upd_pred_taken=0.
  - Same cycle: MispredictE=1.
  - Next cycle, PCF=0x100 -> PredTakenF=1, PredTargetF=0x80; mispred_count=1, upd_count=1.
- Train down from ctr=2: first not-taken update (pred_taken=1) -> MispredictE=1, ctr=1, PredTakenF=0. Second not-taken update -> ctr=0; PredTakenF remains 0.
- Alias: with 0x100 allocated, PCF=0x140 (same index 0, different tag) -> PredTakenF=0.
  - Taken update 0x140 -> 0x300 -> PCF=0x140 predicts 0x300.
  - PCF=0x100 now misses.
- Jump and saturation:
  - upd_is_jump=1, 0x200 -> 0x400 -> ctr=3.
  - One not-taken update -> ctr=2; PredTakenF still 1.
  - Five taken updates -> ctr stays 3.
- Corner cases:
  - Same-cycle update/lookup of 0x100 returns the old value; the new value appears the following cycle.
  - rst asserted mid-sequence with upd_en=1 -> all predictions 0 and stats 0 next cycle.
  - MODE=0 build: taken updates never give PredTakenF=1; upd_count still increments.
